// File: rtl/gbas.sv
// gbas: APB-attached GPIO register block.
//
// Registers, all 8 bits wide and driven straight onto the pins:
//   0x00 oe (RW), 0x01 pu (RW), 0x02 pd (RW), 0x03 a (RW), 0x04 y (RO).
//   Every other address is unmapped. Writes to these addresses are ignored,
//   and reads of them return 0x00.
//
// APB handshake: a transfer is accepted on a rising edge with pselx=1,
// penable=1 and pready=0. pready is then high for exactly one cycle. While
// select is held, the transfer therefore repeats every second cycle.
// prdata is loaded only on accept edges. On a read it takes the addressed
// value. On a write it takes the post-write value of the target.
//
// Ports:
//   pclk    - single clock, all state on its rising edge
//   preset  - synchronous active-high reset
//   paddr   - register address (fully decoded)
//   pwrite  - 1 = write, 0 = read
//   pselx   - slave select
//   penable - APB access phase
//   pwdata  - write data
//   prdata  - registered read data
//   pready  - registered one-cycle transfer-complete pulse
//   y       - GPIO pad input levels
//   oe, pu, pd, a - output-enable, pull-up, pull-down, output-value registers
//
// Build option: define GBAS_Y_SYNC_EN to pass y through a two-flop
// synchronizer (cleared by reset) before it becomes readable at 0x04.
// Without it, a read of 0x04 returns y as sampled at the accept edge.
//
// Bit mapping is defined for DATA_WIDTH = 8.

module gbas #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    input  logic [7:0]            y,
    output logic [7:0]            oe,
    output logic [7:0]            pu,
    output logic [7:0]            pd,
    output logic [7:0]            a
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_OE = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PU = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PD = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_A  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] ADDR_Y  = ADDR_WIDTH'(4);

    logic [7:0]            oe_q;
    logic [7:0]            pu_q;
    logic [7:0]            pd_q;
    logic [7:0]            a_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pready_q;

    logic       accept;
    logic [7:0] wbyte;
    logic [7:0] y_rd;
    logic [7:0] rd_byte;

    // Gating on pready_q keeps a held select from completing on
    // consecutive edges.
    assign accept = pselx & penable & ~pready_q;
    assign wbyte  = 8'(pwdata);

`ifdef GBAS_Y_SYNC_EN
    logic [7:0] y_meta_q;
    logic [7:0] y_sync_q;

    always_ff @(posedge pclk) begin
        if (preset) begin
            y_meta_q <= 8'h00;
            y_sync_q <= 8'h00;
        end else begin
            y_meta_q <= y;
            y_sync_q <= y_meta_q;
        end
    end

    assign y_rd = y_sync_q;
`else
    assign y_rd = y;
`endif

    // Value loaded into prdata on an accept edge. For a write this is the
    // post-write content of the target, so it equals pwdata for the RW
    // registers and is zero for the read-only and unmapped addresses.
    always_comb begin
        rd_byte = 8'h00;
        case (paddr)
            ADDR_OE: rd_byte = pwrite ? wbyte : oe_q;
            ADDR_PU: rd_byte = pwrite ? wbyte : pu_q;
            ADDR_PD: rd_byte = pwrite ? wbyte : pd_q;
            ADDR_A:  rd_byte = pwrite ? wbyte : a_q;
            ADDR_Y:  rd_byte = pwrite ? 8'h00 : y_rd;
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            oe_q     <= 8'h00;
            pu_q     <= 8'h00;
            pd_q     <= 8'h00;
            a_q      <= 8'h00;
            prdata_q <= '0;
            pready_q <= 1'b0;
        end else begin
            // accept is already low whenever pready_q is high, so this both
            // raises the pulse and unconditionally ends it.
            pready_q <= accept;
            if (accept) begin
                prdata_q <= DATA_WIDTH'(rd_byte);
                if (pwrite) begin
                    case (paddr)
                        ADDR_OE: oe_q <= wbyte;
                        ADDR_PU: pu_q <= wbyte;
                        ADDR_PD: pd_q <= wbyte;
                        ADDR_A:  a_q  <= wbyte;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign oe     = oe_q;
    assign pu     = pu_q;
    assign pd     = pd_q;
    assign a      = a_q;
    assign prdata = prdata_q;
    assign pready = pready_q;

endmodule

// File: tb/tb_gbas.sv
module tb_gbas;

    logic       pclk;
    logic       preset;
    logic [7:0] paddr;
    logic       pwrite;
    logic       pselx;
    logic       penable;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic [7:0] y;
    logic [7:0] oe, pu, pd, a;

    int checks = 0;
    int errors = 0;

    // Reference model: register file as a plain array, plus the pad level.
    logic [7:0] reg_m [4];
    logic [7:0] y_m;

    gbas #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pselx   (pselx),
        .penable (penable),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .y       (y),
        .oe      (oe),
        .pu      (pu),
        .pd      (pd),
        .a       (a)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_pins();
        return {reg_m[3], reg_m[2], reg_m[1], reg_m[0]};
    endfunction

    // What a transfer should return, straight from the register map.
    function automatic logic [7:0] model_rd(input logic [7:0] ad, input logic wr,
                                            input logic [7:0] wd);
        if (ad < 8'd4) return wr ? wd : reg_m[ad[1:0]];
        if (ad == 8'd4 && !wr) return y_m;
        return 8'h00;
    endfunction

    function automatic void model_write(input logic [7:0] ad, input logic [7:0] wd);
        if (ad < 8'd4) reg_m[ad[1:0]] = wd;
    endfunction

    // One APB transfer: setup cycle, access cycle, then idle.
    // rdy = pready after the accept edge, rdy_next = pready one cycle later.
    task automatic xfer(input logic [7:0] ad, input logic wr, input logic [7:0] wd,
                        output logic [7:0] rd, output logic rdy, output logic rdy_next,
                        output logic [31:0] pins);
        @(negedge pclk);
        paddr = ad; pwrite = wr; pwdata = wd; pselx = 1'b1; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        @(posedge pclk); #1;
        rd = prdata; rdy = pready; pins = {a, pd, pu, oe};
        @(negedge pclk);
        pselx = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        rdy_next = pready;
    endtask

    task automatic set_y_settled(input logic [7:0] v);
        @(negedge pclk);
        y = v; y_m = v;
        repeat (3) @(posedge pclk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) reg_m[i] = 8'h00;
    endtask

    task automatic test_reset();
        logic [7:0] rd; logic r0, r1; logic [31:0] pins;
        @(negedge pclk); preset = 1'b1;
        @(posedge pclk); #1;
        @(negedge pclk); preset = 1'b0;
        clear_model();
        checks++; if ({oe, pu, pd, a} !== 32'h0)
            begin errors++; $display("FAIL reset_regs: got %h want 0", {oe, pu, pd, a}); end
        checks++; if (prdata !== 8'h00 || pready !== 1'b0)
            begin errors++; $display("FAIL reset_bus: prdata %h pready %b want 00/0", prdata, pready); end
        // Dirty state, then reset again
        for (int i = 0; i < 4; i++) xfer(8'(i), 1'b1, 8'hC3 ^ 8'(i), rd, r0, r1, pins);
        @(negedge pclk); preset = 1'b1;
        @(posedge pclk); #1;
        @(negedge pclk); preset = 1'b0;
        checks++; if ({oe, pu, pd, a, prdata} !== 40'h0 || pready !== 1'b0)
            begin errors++; $display("FAIL reset_again: got %h pready %b want 0", {oe, pu, pd, a, prdata}, pready); end
    endtask

    // Reset coinciding with an accept must win; then the held access is serviced.
    task automatic test_reset_priority();
        @(negedge pclk);
        paddr = 8'd1; pwrite = 1'b1; pwdata = 8'h5A; pselx = 1'b1; penable = 1'b1; preset = 1'b1;
        @(posedge pclk); #1;
        checks++; if (pready !== 1'b0 || pu !== 8'h00)
            begin errors++; $display("FAIL reset_prio: pready %b pu %h want 0/00", pready, pu); end
        @(negedge pclk); preset = 1'b0;
        @(posedge pclk); #1;
        reg_m[1] = 8'h5A;
        checks++; if (pready !== 1'b1 || pu !== 8'h5A || prdata !== 8'h5A)
            begin errors++; $display("FAIL post_reset_accept: pready %b pu %h prdata %h want 1/5a/5a", pready, pu, prdata); end
        // Reset in the cycle where pready is high aborts the repeat
        @(negedge pclk); preset = 1'b1;
        @(posedge pclk); #1;
        clear_model();
        checks++; if (pready !== 1'b0 || pu !== 8'h00)
            begin errors++; $display("FAIL mid_reset: pready %b pu %h want 0/00", pready, pu); end
        @(negedge pclk); preset = 1'b0; pselx = 1'b0; penable = 1'b0;
        @(posedge pclk);
    endtask

    task automatic test_write_pass();
        logic [7:0] v, rd; logic r0, r1; logic [31:0] pins;
        for (int ad = 0; ad < 4; ad++) begin
            v = 8'h01;
            for (int k = 0; k < 16; k++) begin
                xfer(8'(ad), 1'b1, v, rd, r0, r1, pins);
                model_write(8'(ad), v);
                checks++; if (pins !== model_pins() || rd !== v)
                    begin errors++; $display("FAIL write_pass a%0d: pins %h prdata %h want %h/%h", ad, pins, rd, model_pins(), v); end
                checks++; if (r0 !== 1'b1 || r1 !== 1'b0)
                    begin errors++; $display("FAIL write_pulse a%0d: pready %b,%b want 1,0", ad, r0, r1); end
                v = (k < 7) ? {v[6:0], 1'b1} : (v >> 1);
            end
        end
    endtask

    task automatic test_read_y();
        logic [7:0] rd; logic r0, r1; logic [31:0] pins;
        for (int v = 0; v < 256; v++) begin
            set_y_settled(8'(v));
            xfer(8'd4, 1'b0, 8'h00, rd, r0, r1, pins);
            checks++; if (rd !== model_rd(8'd4, 1'b0, 8'h00) || r0 !== 1'b1)
                begin errors++; $display("FAIL read_y: prdata %h pready %b want %h/1", rd, r0, model_rd(8'd4, 1'b0, 8'h00)); end
        end
    endtask

    task automatic test_readback();
        logic [7:0] rd; logic r0, r1; logic [31:0] pins;
        for (int ad = 0; ad < 4; ad++) begin
            for (int v = 0; v < 256; v++) begin
                xfer(8'(ad), 1'b1, 8'(v), rd, r0, r1, pins);
                model_write(8'(ad), 8'(v));
                xfer(8'(ad), 1'b0, 8'h00, rd, r0, r1, pins);
                checks++; if (rd !== reg_m[ad] || pins[ad*8 +: 8] !== reg_m[ad] || pins !== model_pins())
                    begin errors++; $display("FAIL readback a%0d: prdata %h pin %h want %h", ad, rd, pins[ad*8 +: 8], reg_m[ad]); end
            end
        end
    endtask

    task automatic test_held_select();
        logic [7:0] rd; logic r0, r1; logic [31:0] pins;
        xfer(8'd3, 1'b1, 8'h00, rd, r0, r1, pins);
        model_write(8'd3, 8'h00);
        @(negedge pclk);
        paddr = 8'd3; pwrite = 1'b1; pwdata = 8'hA5; pselx = 1'b1; penable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge pclk); #1;
            checks++; if (pready !== ((k % 2) == 1))
                begin errors++; $display("FAIL held_pready edge%0d: got %b want %b", k, pready, (k % 2) == 1); end
        end
        @(negedge pclk); pselx = 1'b0; penable = 1'b0;
        model_write(8'd3, 8'hA5);
        checks++; if (a !== 8'hA5 || prdata !== 8'hA5)
            begin errors++; $display("FAIL held_value: a %h prdata %h want a5/a5", a, prdata); end
    endtask

    task automatic test_unmapped();
        logic [7:0] rd; logic r0, r1; logic [31:0] pins;
        xfer(8'd7, 1'b1, 8'h55, rd, r0, r1, pins);
        checks++; if (pins !== model_pins() || rd !== 8'h00 || r0 !== 1'b1 || r1 !== 1'b0)
            begin errors++; $display("FAIL unmapped_wr: pins %h prdata %h pready %b%b want %h/00/10", pins, rd, r0, r1, model_pins()); end
        xfer(8'd7, 1'b0, 8'h00, rd, r0, r1, pins);
        checks++; if (pins !== model_pins() || rd !== 8'h00 || r0 !== 1'b1 || r1 !== 1'b0)
            begin errors++; $display("FAIL unmapped_rd: pins %h prdata %h pready %b%b want %h/00/10", pins, rd, r0, r1, model_pins()); end
        // Write to the read-only y address also has no effect
        xfer(8'd4, 1'b1, 8'hFF, rd, r0, r1, pins);
        checks++; if (pins !== model_pins() || rd !== 8'h00)
            begin errors++; $display("FAIL ro_write: pins %h prdata %h want %h/00", pins, rd, model_pins()); end
    endtask

    // Half-formed accesses must leave registers and prdata alone.
    task automatic test_idle_hold();
        logic [7:0] rd; logic r0, r1; logic [31:0] pins;
        xfer(8'd0, 1'b1, 8'h3C, rd, r0, r1, pins);
        model_write(8'd0, 8'h3C);
        @(negedge pclk);
        paddr = 8'd0; pwrite = 1'b1; pwdata = 8'hFF; pselx = 1'b1; penable = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk); pselx = 1'b0; penable = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        checks++; if ({a, pd, pu, oe} !== model_pins() || prdata !== 8'h3C || pready !== 1'b0)
            begin errors++; $display("FAIL idle_hold: pins %h prdata %h pready %b want %h/3c/0", {a, pd, pu, oe}, prdata, pready, model_pins()); end
        @(negedge pclk); penable = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] ad, wd, rd, exp; logic wr, r0, r1; logic [31:0] pins;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) set_y_settled(8'($urandom));
            ad = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            wr = 1'($urandom);
            wd = 8'($urandom);
            exp = model_rd(ad, wr, wd);
            if (wr) model_write(ad, wd);
            xfer(ad, wr, wd, rd, r0, r1, pins);
            checks++; if (rd !== exp || pins !== model_pins() || r0 !== 1'b1 || r1 !== 1'b0)
                begin errors++; $display("FAIL random ad %h wr %b: prdata %h pins %h pready %b%b want %h/%h/10", ad, wr, rd, pins, r0, r1, exp, model_pins()); end
        end
    endtask

    initial begin
        preset = 1'b1; paddr = 8'h00; pwrite = 1'b0; pselx = 1'b0; penable = 1'b0;
        pwdata = 8'h00; y = 8'h00; y_m = 8'h00;
        clear_model();
        test_reset();
        test_reset_priority();
        test_write_pass();
        test_read_y();
        test_readback();
        test_held_select();
        test_unmapped();
        test_idle_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
